// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter for the register-bank write demux: three requesters share one
// write port, one registered grant per two cycles, driving the demux select/data bus.
module regbank_wr_arbiter #(
    parameter int unsigned    PA_DATA  = 32,
    parameter int unsigned    PA_SEL   = 9,
    parameter logic [PA_SEL-1:0] IDLE_SEL = 9'h1FF
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               stall,
    input  logic [2:0]         req,
    input  logic [4:0]         addr0,
    input  logic [4:0]         addr1,
    input  logic [4:0]         addr2,
    input  logic [PA_DATA-1:0] data0,
    input  logic [PA_DATA-1:0] data1,
    input  logic [PA_DATA-1:0] data2,
    output logic [2:0]         ack,
    output logic               err,
    output logic [PA_SEL-1:0]  sel,
    output logic [PA_DATA-1:0] wdata,
    output logic               wr_valid,
    output logic [15:0]        wr_count,
    output logic               dbg_state
);

    // Handshake: a requester raises req with stable addr/data and holds them until its
    // one-cycle ack pulse; the request counts as consumed in that ack cycle.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    localparam logic [PA_SEL-1:0] PC_SEL = PA_SEL'(9'h0FF);

    state_t               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [2:0]           ack_q, ack_d;
    logic                 err_q, err_d;
    logic [PA_SEL-1:0]    sel_q, sel_d;
    logic [PA_DATA-1:0]   wdata_q, wdata_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [15:0]          wr_count_q, wr_count_d;

    logic                 grant_found;
    logic [1:0]           win;
    logic [2:0]           cand;
    logic [4:0]           win_addr;
    logic [PA_DATA-1:0]   win_data;

    // Rotating priority search: ptr, ptr+1, ptr+2 (mod 3), first asserted req wins.
    always_comb begin
        grant_found = 1'b0;
        win         = 2'd0;
        cand        = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, ptr_q} + 3'(i);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!grant_found && req[cand[1:0]]) begin
                grant_found = 1'b1;
                win         = cand[1:0];
            end
        end
    end

    always_comb begin
        win_addr = addr0;
        win_data = data0;
        case (win)
            2'd1:    begin win_addr = addr1; win_data = data1; end
            2'd2:    begin win_addr = addr2; win_data = data2; end
            default: begin win_addr = addr0; win_data = data0; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ack_d      = 3'b000;
        err_d      = 1'b0;
        sel_d      = IDLE_SEL;
        wdata_d    = '0;
        wr_valid_d = 1'b0;
        wr_count_d = wr_count_q;
        case (state_q)
            S_IDLE: begin
                if (!stall && grant_found) begin
                    state_d    = S_ISSUE;
                    ack_d      = 3'b001 << win;
                    ptr_d      = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    if (win_addr <= 5'd16) begin
                        sel_d      = (win_addr == 5'd16) ? PC_SEL : PA_SEL'(win_addr[3:0]);
                        wdata_d    = win_data;
                        wr_valid_d = 1'b1;
                        if (wr_count_q != 16'hFFFF) begin
                            wr_count_d = wr_count_q + 16'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            ptr_q      <= 2'd0;
            ack_q      <= 3'b000;
            err_q      <= 1'b0;
            sel_q      <= IDLE_SEL;
            wdata_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            wr_valid_q <= wr_valid_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign sel       = sel_q;
    assign wdata     = wdata_q;
    assign wr_valid  = wr_valid_q;
    assign wr_count  = wr_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench for regbank_wr_arbiter: hand-computed expectations for single writes,
// round-robin order, PC target, invalid address, stall and reset during a grant.
module tb_regbank_wr_arbiter;

    logic        clk;
    logic        rst_b;
    logic        stall;
    logic [2:0]  req;
    logic [4:0]  addr0, addr1, addr2;
    logic [31:0] data0, data1, data2;
    logic [2:0]  ack;
    logic        err;
    logic [8:0]  sel;
    logic [31:0] wdata;
    logic        wr_valid;
    logic [15:0] wr_count;
    logic        dbg_state;

    int n_checks;
    int n_errors;

    regbank_wr_arbiter dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .stall     (stall),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .ack       (ack),
        .err       (err),
        .sel       (sel),
        .wdata     (wdata),
        .wr_valid  (wr_valid),
        .wr_count  (wr_count),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        stall = 1'b0;
        req   = 3'b000;
        addr0 = 5'd0; addr1 = 5'd0; addr2 = 5'd0;
        data0 = 32'd0; data1 = 32'd0; data2 = 32'd0;
        step();
        step();
        rst_b = 1'b1;
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_count);
        check({tag, "_ack"},   32'(ack),      32'h0);
        check({tag, "_sel"},   32'(sel),      32'h1FF);
        check({tag, "_wv"},    32'(wr_valid), 32'h0);
        check({tag, "_cnt"},   32'(wr_count), 32'(exp_count));
    endtask

    logic [2:0] exp_ack3 [4];

    initial begin
        n_checks = 0;
        n_errors = 0;

        // reset values
        do_reset();
        check("rst_ack",   32'(ack),      32'h0);
        check("rst_err",   32'(err),      32'h0);
        check("rst_sel",   32'(sel),      32'h1FF);
        check("rst_wdata", wdata,         32'h0);
        check("rst_wv",    32'(wr_valid), 32'h0);
        check("rst_cnt",   32'(wr_count), 32'h0);

        // 1: single write to reg5
        req = 3'b001; addr0 = 5'd5; data0 = 32'hDEADBEEF;
        step();
        check("t1_ack",   32'(ack),      32'h1);
        check("t1_sel",   32'(sel),      32'h005);
        check("t1_wdata", wdata,         32'hDEADBEEF);
        check("t1_wv",    32'(wr_valid), 32'h1);
        check("t1_err",   32'(err),      32'h0);
        req = 3'b000;
        step();
        check_idle("t1_after", 16'd1);
        check("t1_wdata0", wdata, 32'h0);

        // 2: all three requesting from ptr=0
        do_reset();
        req = 3'b111; addr0 = 5'd1; addr1 = 5'd2; addr2 = 5'd3;
        data0 = 32'hA0; data1 = 32'hA1; data2 = 32'hA2;
        step();
        check("t2_ack0", 32'(ack), 32'h1);
        check("t2_sel0", 32'(sel), 32'h001);
        req[0] = 1'b0;
        step();
        check("t2_gap0", 32'(ack), 32'h0);
        step();
        check("t2_ack1", 32'(ack), 32'h2);
        check("t2_wd1",  wdata,    32'hA1);
        req[1] = 1'b0;
        step();
        check("t2_gap1", 32'(ack), 32'h0);
        step();
        check("t2_ack2", 32'(ack), 32'h4);
        check("t2_sel2", 32'(sel), 32'h003);
        req[2] = 1'b0;
        step();
        check_idle("t2_end", 16'd3);

        // 3: req0 re-asserted after each ack, req1 held -> alternate 0,1,0,1
        do_reset();
        exp_ack3[0] = 3'b001; exp_ack3[1] = 3'b010;
        exp_ack3[2] = 3'b001; exp_ack3[3] = 3'b010;
        req = 3'b011; addr0 = 5'd7; addr1 = 5'd8;
        for (int g = 0; g < 4; g++) begin
            step();
            check($sformatf("t3_ack%0d", g), 32'(ack), 32'(exp_ack3[g]));
            if (ack[0]) req[0] = 1'b0;
            step();
            check($sformatf("t3_gap%0d", g), 32'(ack), 32'h0);
            req[0] = 1'b1;
        end
        req = 3'b000;
        step();
        check("t3_cnt", 32'(wr_count), 32'd4);

        // 4: PC write
        req = 3'b100; addr2 = 5'd16; data2 = 32'h100;
        step();
        check("t4_ack",   32'(ack),      32'h4);
        check("t4_sel",   32'(sel),      32'h0FF);
        check("t4_wdata", wdata,         32'h100);
        check("t4_wv",    32'(wr_valid), 32'h1);
        req = 3'b000;
        step();
        check_idle("t4_after", 16'd5);

        // 5: invalid address from requester 1
        req = 3'b010; addr1 = 5'd20; data1 = 32'hBAD;
        step();
        check("t5_ack",   32'(ack),      32'h2);
        check("t5_err",   32'(err),      32'h1);
        check("t5_wv",    32'(wr_valid), 32'h0);
        check("t5_sel",   32'(sel),      32'h1FF);
        check("t5_wdata", wdata,         32'h0);
        check("t5_cnt",   32'(wr_count), 32'd5);
        req = 3'b000;
        step();
        check("t5_err0", 32'(err), 32'h0);
        // ptr must now be 2: requester 2 wins a three-way tie
        req = 3'b111; addr0 = 5'd1; addr1 = 5'd2; addr2 = 5'd9; data2 = 32'h99;
        step();
        check("t5_ptr_ack", 32'(ack), 32'h4);
        check("t5_ptr_sel", 32'(sel), 32'h009);
        req = 3'b000;
        step();
        check_idle("t5_end", 16'd6);

        // 6: stall holds off the grant
        stall = 1'b1; req = 3'b001; addr0 = 5'd12; data0 = 32'h1234;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("t6_stall%0d", c), 32'({ack, wr_valid}), 32'h0);
        end
        stall = 1'b0;
        step();
        check("t6_ack",   32'(ack),      32'h1);
        check("t6_sel",   32'(sel),      32'h00C);
        check("t6_wv",    32'(wr_valid), 32'h1);
        check("t6_cnt",   32'(wr_count), 32'd7);
        // asynchronous reset in the middle of the ISSUE cycle
        rst_b = 1'b0;
        #1;
        check("t6_rst_ack", 32'(ack),      32'h0);
        check("t6_rst_wv",  32'(wr_valid), 32'h0);
        check("t6_rst_sel", 32'(sel),      32'h1FF);
        check("t6_rst_cnt", 32'(wr_count), 32'h0);
        req = 3'b000;
        step();
        rst_b = 1'b1;
        step();
        check_idle("t6_end", 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
